bh1750_i2c_slave: RTL and testbench

BH1750_I2C_SLAVE -- requirements
Module: bh1750_i2c_slave

---
 rtl/bh1750_i2c_slave.sv | 187 ++++++++++++++++++
 tb/tb_bh1750_i2c_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bh1750_i2c_slave.sv
// BH1750-style I2C slave: accepts opcode writes, returns a 16-bit lux value on reads.
// All bus activity is sampled through synchronizers clocked by sys_clk.
module bh1750_i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'b1011100
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] lux,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        powered,
    output logic [7:0]  mode,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  scl_sr, sda_sr;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  rx, rx_n;
    logic [15:0] sh, sh_n;
    logic        sda_oe, oe_n;
    logic        ack_ok, ack_n;
    logic [7:0]  cmd_n, mode_n;
    logic        cv_n, pw_n, legal;

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    // [1] is the synchronized value, [2] the delayed copy used for edge detection
    assign scl_s     = scl_sr[1];
    assign scl_d     = scl_sr[2];
    assign sda_s     = sda_sr[1];
    assign sda_d     = sda_sr[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign SDA  = sda_oe ? 1'b0 : 1'bz;
    assign busy = state inside {ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            scl_sr    <= '1;
            sda_sr    <= '1;
            state     <= IDLE;
            cnt       <= '0;
            rx        <= '0;
            sh        <= '0;
            sda_oe    <= 1'b0;
            ack_ok    <= 1'b0;
            cmd       <= 8'h00;
            cmd_valid <= 1'b0;
            powered   <= 1'b0;
            mode      <= 8'h10;
        end else begin
            scl_sr    <= {scl_sr[1:0], SCL};
            sda_sr    <= {sda_sr[1:0], SDA};
            state     <= state_n;
            cnt       <= cnt_n;
            rx        <= rx_n;
            sh        <= sh_n;
            sda_oe    <= oe_n;
            ack_ok    <= ack_n;
            cmd       <= cmd_n;
            cmd_valid <= cv_n;
            powered   <= pw_n;
            mode      <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx;
        sh_n    = sh;
        oe_n    = sda_oe;
        ack_n   = ack_ok;
        cmd_n   = cmd;
        cv_n    = 1'b0;
        pw_n    = powered;
        mode_n  = mode;
        legal   = 1'b0;
        if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR, WR_BYTE: begin
                    if (scl_rise) begin
                        rx_n  = {rx[6:0], sda_s};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        if (state == WR_BYTE) begin
                            state_n = WR_ACK;
                            oe_n    = 1'b1;
                        end else if (rx[7:1] == DEV_ADDR) begin
                            state_n = ADDR_ACK;
                            oe_n    = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n = '0;
                        if (rx[0]) begin
                            // first read bit goes out on the same edge that ends the ACK
                            oe_n    = ~lux[15];
                            sh_n    = {lux[14:0], 1'b1};
                            state_n = RD_BYTE;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = WR_BYTE;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = WR_BYTE;
                        case (rx)
                            8'h00: begin legal = 1'b1; pw_n = 1'b0; end
                            8'h01: begin legal = 1'b1; pw_n = 1'b1; end
                            8'h07: begin
                                legal = 1'b1;
                                if (powered) sh_n = '0;
                            end
                            8'h10, 8'h11, 8'h13, 8'h20, 8'h21, 8'h23: begin
                                legal  = 1'b1;
                                mode_n = rx;
                                pw_n   = 1'b1;
                            end
                            default: legal = 1'b0;
                        endcase
                        if (legal) begin
                            cmd_n = rx;
                            cv_n  = 1'b1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            state_n = RD_ACK;
                        end else begin
                            oe_n = ~sh[15];
                            sh_n = {sh[14:0], 1'b1};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ack_n = ~sda_s;
                    end else if (scl_fall) begin
                        if (ack_ok) begin
                            oe_n    = ~sh[15];
                            sh_n    = {sh[14:0], 1'b1};
                            cnt_n   = '0;
                            state_n = RD_BYTE;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bh1750_i2c_slave.sv
// Directed bench for bh1750_i2c_slave: bit-banged I2C master with open-drain SDA.
`timescale 1ns/1ps
module tb_bh1750_i2c_slave;

    logic        sys_clk;
    logic        rst;
    logic        scl_m;
    logic        m_low;
    logic [15:0] lux;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic        powered;
    logic [7:0]  mode;
    logic        busy;
    wire         SDA;

    int checks = 0;
    int passed = 0;
    int cv_count = 0;
    int cv_base;
    logic       ack;
    logic [7:0] rd;

    assign SDA = m_low ? 1'b0 : 1'bz;
    pullup (SDA);

    bh1750_i2c_slave #(.DEV_ADDR(7'b1011100)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .SCL      (scl_m),
        .SDA      (SDA),
        .lux      (lux),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .powered  (powered),
        .mode     (mode),
        .busy     (busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) if (cmd_valid === 1'b1) cv_count++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #100;
        scl_m = 1'b1; #200;
        m_low = 1'b1; #200;
        scl_m = 1'b0; #100;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #100;
        scl_m = 1'b1; #200;
        m_low = 1'b0; #200;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; #100;
            scl_m = 1'b1;  #200;
            scl_m = 1'b0;  #100;
        end
        m_low = 1'b0; #100;
        scl_m = 1'b1; #100;
        a = (SDA === 1'b0);
        #100;
        scl_m = 1'b0; #100;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_low = 1'b0; #100;
            scl_m = 1'b1; #100;
            b[i] = (SDA !== 1'b0);
            #100;
            scl_m = 1'b0; #100;
        end
        m_low = master_ack; #100;
        scl_m = 1'b1; #200;
        scl_m = 1'b0; #100;
        m_low = 1'b0;
    endtask

    initial begin
        rst = 1'b1; scl_m = 1'b1; m_low = 1'b0; lux = 16'h0000;
        #50;
        rst = 1'b0;
        #50;
        chk("rst_cmd", {8'h00, cmd}, 16'h0000);
        chk("rst_cmd_valid", {15'd0, cmd_valid}, 16'h0000);
        chk("rst_powered", {15'd0, powered}, 16'h0000);
        chk("rst_mode", {8'h00, mode}, 16'h0010);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_sda", {15'd0, SDA}, 16'h0001);

        // power on
        cv_base = cv_count;
        i2c_start();
        send_byte(8'hB8, ack); chk("pon_addr_ack", {15'd0, ack}, 16'h0001);
        chk("pon_busy", {15'd0, busy}, 16'h0001);
        send_byte(8'h01, ack); chk("pon_data_ack", {15'd0, ack}, 16'h0001);
        i2c_stop();
        chk("pon_cmd", {8'h00, cmd}, 16'h0001);
        chk("pon_powered", {15'd0, powered}, 16'h0001);
        chk("pon_busy_after_stop", {15'd0, busy}, 16'h0000);
        chk("pon_cv_pulses", 16'(cv_count - cv_base), 16'h0001);

        // mode set, then illegal opcode
        cv_base = cv_count;
        i2c_start();
        send_byte(8'hB8, ack); chk("mode_addr_ack", {15'd0, ack}, 16'h0001);
        send_byte(8'h21, ack); chk("mode_data_ack", {15'd0, ack}, 16'h0001);
        i2c_stop();
        chk("mode_val", {8'h00, mode}, 16'h0021);
        chk("mode_powered", {15'd0, powered}, 16'h0001);
        chk("mode_cv_pulses", 16'(cv_count - cv_base), 16'h0001);
        cv_base = cv_count;
        i2c_start();
        send_byte(8'hB8, ack);
        send_byte(8'h55, ack); chk("illegal_ack", {15'd0, ack}, 16'h0001);
        i2c_stop();
        chk("illegal_cmd", {8'h00, cmd}, 16'h0021);
        chk("illegal_mode", {8'h00, mode}, 16'h0021);
        chk("illegal_cv_pulses", 16'(cv_count - cv_base), 16'h0000);

        // read two bytes
        lux = 16'hA53C;
        i2c_start();
        send_byte(8'hB9, ack); chk("rd_addr_ack", {15'd0, ack}, 16'h0001);
        recv_byte(1'b1, rd); chk("rd_msb", {8'h00, rd}, 16'h00A5);
        recv_byte(1'b0, rd); chk("rd_lsb", {8'h00, rd}, 16'h003C);
        #100;
        chk("rd_sda_released", {15'd0, SDA}, 16'h0001);
        chk("rd_busy_after_nack", {15'd0, busy}, 16'h0000);
        i2c_stop();

        // foreign address
        cv_base = cv_count;
        i2c_start();
        send_byte(8'h46, ack); chk("foreign_nack", {15'd0, ack}, 16'h0000);
        chk("foreign_busy", {15'd0, busy}, 16'h0000);
        send_byte(8'h00, ack); chk("foreign_data_nack", {15'd0, ack}, 16'h0000);
        chk("foreign_powered", {15'd0, powered}, 16'h0001);
        chk("foreign_cmd", {8'h00, cmd}, 16'h0021);
        i2c_stop();
        chk("foreign_cv_pulses", 16'(cv_count - cv_base), 16'h0000);

        // power down then repeated START into a read
        i2c_start();
        send_byte(8'hB8, ack);
        send_byte(8'h00, ack); chk("pdn_ack", {15'd0, ack}, 16'h0001);
        chk("pdn_powered", {15'd0, powered}, 16'h0000);
        i2c_start();
        send_byte(8'hB9, ack); chk("rs_addr_ack", {15'd0, ack}, 16'h0001);
        recv_byte(1'b0, rd); chk("rs_rd", {8'h00, rd}, 16'h00A5);
        i2c_stop();
        chk("rs_cmd", {8'h00, cmd}, 16'h0000);
        chk("rs_mode", {8'h00, mode}, 16'h0021);

        // reset while the slave holds SDA low
        lux = 16'h00FF;
        i2c_start();
        send_byte(8'hB9, ack);
        chk("rr_sda_driven", {15'd0, SDA}, 16'h0000);
        rst = 1'b1;
        #1;
        chk("rr_sda_released", {15'd0, SDA}, 16'h0001);
        #29;
        chk("rr_cmd", {8'h00, cmd}, 16'h0000);
        chk("rr_mode", {8'h00, mode}, 16'h0010);
        chk("rr_powered", {15'd0, powered}, 16'h0000);
        chk("rr_busy", {15'd0, busy}, 16'h0000);
        chk("rr_cmd_valid", {15'd0, cmd_valid}, 16'h0000);
        rst = 1'b0;
        #100;
        i2c_start();
        send_byte(8'hB8, ack); chk("post_rst_addr_ack", {15'd0, ack}, 16'h0001);
        send_byte(8'h01, ack); chk("post_rst_data_ack", {15'd0, ack}, 16'h0001);
        i2c_stop();
        chk("post_rst_cmd", {8'h00, cmd}, 16'h0001);
        chk("post_rst_powered", {15'd0, powered}, 16'h0001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
